sd_clk_switch_ctrl: RTL and testbench
=====================================

// Module: sd_clk_switch_ctrl
// PURPOSE
//  Decides when the SD clock mux may change between slow (identification) and fast (transfer) clock.
//  Sits directly upstream of the PLL/DCS clock divider and drives its select input (0 = slow, 1 = fast).
//  Holds off the SD command/data engines, waits for the bus to be idle, flips the select, then waits for the clock to settle.
//  Reports when the SD clock is usable again.
// PARAMETERS
//  IDLE_CYCLES     8      consecutive idle iclk cycles required in DRAIN before switching (>=1)
//  SETTLE_CYCLES   64     iclk cycles waited after select change / PLL lock before clock is ready (>=1)
//  TIMEOUT_CYCLES  65536  max DRAIN length in iclk cycles; used only with CLK_SWITCH_TIMEOUT_EN
// PORTS
//  iclk          in   1  reference clock; all logic on rising edge
//  irst          in   1  synchronous, active-high reset
//  ipll_lock     in   1  PLL lock indicator; level, already synchronised to iclk
//  ireq_fast     in   1  requested mode, level: 0 = slow, 1 = fast
//  ibus_busy     in   1  CMD/DAT transaction in progress
//  osel_clk      out  1  clock select to the divider: 0 = slow, 1 = fast
//  ohold         out  1  engines must not start new transactions while high
//  oclk_ready    out  1  SD clock stable at the mode shown on osel_clk
//  oswitch_done  out  1  one-cycle pulse on completion of a mode switch
//  otimeout      out  1  sticky drain-timeout flag; tied 0 without CLK_SWITCH_TIMEOUT_EN
// BEHAVIOUR
//  Reset: state LOCK_WAIT. osel_clk=0, ohold=1, oclk_ready=0, oswitch_done=0, otimeout=0. All counters 0.
//  FSM states: LOCK_WAIT, STABLE, DRAIN, SWITCH, SETTLE. All outputs are registered.
//  LOCK_WAIT: ohold=1, oclk_ready=0. On ipll_lock=1 -> SETTLE; the switch flag is cleared, so no done pulse.
//  STABLE: ohold=0, oclk_ready=1. If ireq_fast != osel_clk -> DRAIN next cycle, and ohold rises on that same edge.
//  DRAIN: ohold=1, oclk_ready=1.
//   - Idle counter increments each cycle with ibus_busy=0 and clears to 0 on ibus_busy=1.
//   - When the counter reaches IDLE_CYCLES -> SWITCH.
//   - If ireq_fast returns to equal osel_clk -> STABLE (abort). No select change, no pulse, ohold drops next cycle.
//  SWITCH: single cycle; oclk_ready=0. osel_clk <= ireq_fast as sampled in this cycle; switch flag is set. -> SETTLE.
//  SETTLE: ohold=1, oclk_ready=0. Counts SETTLE_CYCLES cycles, then -> STABLE.
//   - oswitch_done=1 on the first STABLE cycle, but only if the switch flag is set.
//   - ireq_fast is ignored during SETTLE and re-evaluated in STABLE; back-to-back switches are allowed.
//  Latency, bus idle, defaults: ireq_fast toggles at cycle 0 (in STABLE).
//   - DRAIN occupies cycles 1..8, SWITCH cycle 9.
//   - osel_clk changes at cycle 10.
//   - oclk_ready=1 and oswitch_done=1 at cycle 74.
//  PLL lock loss: ipll_lock=0 in any state other than LOCK_WAIT -> LOCK_WAIT next cycle.
//   - osel_clk forced 0, ohold=1, oclk_ready=0. The in-progress switch is dropped without a pulse.
//  irst mid-operation: every output returns to its reset value on the next edge, whatever the state.
//  ibus_busy is ignored outside DRAIN.
//  Counters saturate and never wrap. Widths come from $clog2(param+1).
// CONFIGURATION
//  CLK_SWITCH_TIMEOUT_EN defined:
//   - A DRAIN cycle counter (cleared on DRAIN entry) runs alongside the idle counter.
//   - On reaching TIMEOUT_CYCLES -> STABLE. osel_clk is unchanged and otimeout is set.
//   - otimeout clears on the next oswitch_done, on lock loss, or on reset.
//   - If the timeout and the idle threshold are reached in the same cycle, the switch wins.
//  CLK_SWITCH_TIMEOUT_EN undefined: DRAIN waits indefinitely, no timeout counter exists, otimeout is constant 0.
// STRUCTURE
//  Shared package sd_clk_pkg holds:
//   - the state encoding localparams (ST_LOCK_WAIT..ST_SETTLE)
//   - the default IDLE/SETTLE/TIMEOUT constants
//   - the mode encoding (MODE_SLOW=0, MODE_FAST=1), shared with the clock divider.
//  One sub-module, sd_cycle_counter: parameterised saturating up-counter with clear/enable and a terminal-count output.
//   - Instantiated for the idle and settle counts, and for the timeout count when enabled.
// TESTING
//  1 Reset, then ipll_lock=1 at cycle 5: oclk_ready=1 and ohold=0 at cycle 70, osel_clk=0, no oswitch_done.
//  2 In STABLE, ireq_fast=1 with bus idle: osel_clk=1 exactly 10 cycles later, oclk_ready and oswitch_done 74 cycles later.
//  3 In DRAIN, pulse ibus_busy on drain cycle 5: idle count restarts, SWITCH is delayed until 8 idle cycles follow the busy cycle.
//  4 ireq_fast 0->1 then back to 0 after 3 drain cycles: STABLE, osel_clk stays 0, no pulse, ohold low 1 cycle after the abort.
//  5 Drop ipll_lock during SETTLE: LOCK_WAIT next cycle, osel_clk=0, oclk_ready=0, no pulse; relock recovers via SETTLE.
//  6 TIMEOUT_CYCLES=100 with CLK_SWITCH_TIMEOUT_EN and ibus_busy held 1: otimeout=1 and STABLE after 100 DRAIN cycles, osel_clk unchanged.

Source files
------------

// File: rtl/sd_clk_pkg.sv
// sd_clk_pkg: shared definitions for the SD clock switch controller and the
// clock divider it feeds.
//   - sd_clk_state_e : controller states ST_LOCK_WAIT..ST_SETTLE
//   - DEF_*_CYCLES   : default idle / settle / drain-timeout cycle counts
//   - MODE_SLOW/FAST : clock select encoding (0 = slow, 1 = fast)
package sd_clk_pkg;

  typedef enum logic [2:0] {
    ST_LOCK_WAIT,
    ST_STABLE,
    ST_DRAIN,
    ST_SWITCH,
    ST_SETTLE
  } sd_clk_state_e;

  localparam int unsigned DEF_IDLE_CYCLES    = 8;
  localparam int unsigned DEF_SETTLE_CYCLES  = 64;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 65536;

  localparam logic MODE_SLOW = 1'b0;
  localparam logic MODE_FAST = 1'b1;

endpackage

// File: rtl/sd_cycle_counter.sv
// sd_cycle_counter: saturating up-counter with synchronous clear and enable.
//   clk, rst : clock and synchronous active-high reset
//   clr      : synchronous clear to zero (wins over en)
//   en       : count this cycle
//   hit      : count reaches TARGET on the coming edge (or is already there
//              with en high); lets the owner change state on that same edge
module sd_cycle_counter #(
  parameter int unsigned TARGET = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int unsigned W = $clog2(TARGET + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (32'(count) < TARGET)) begin
      count <= count + W'(1);
    end
  end

  assign hit = en && !clr && ((32'(count) + 32'd1) >= TARGET);

endmodule

// File: rtl/sd_clk_switch_ctrl.sv
// sd_clk_switch_ctrl: sequences changes of the SD clock select between slow
// (identification) and fast (transfer) clock. Holds the CMD/DAT engines off,
// waits for an idle bus, flips the select, then waits for the clock to settle.
//   iclk, irst    : reference clock, synchronous active-high reset
//   ipll_lock     : PLL lock level (already in iclk domain)
//   ireq_fast     : requested mode level (0 = slow, 1 = fast)
//   ibus_busy     : CMD/DAT transaction in progress
//   osel_clk      : clock select to the divider (0 = slow, 1 = fast)
//   ohold         : engines must not start new transactions
//   oclk_ready    : SD clock stable at the mode shown on osel_clk
//   oswitch_done  : one-cycle pulse when a mode switch completes
//   otimeout      : sticky drain-timeout flag
// Optional feature: define CLK_SWITCH_TIMEOUT_EN to bound DRAIN to
// TIMEOUT_CYCLES; otherwise DRAIN waits indefinitely and otimeout is 0.
module sd_clk_switch_ctrl
  import sd_clk_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES    = DEF_IDLE_CYCLES,
  parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES
`ifdef CLK_SWITCH_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic iclk,
  input  logic irst,
  input  logic ipll_lock,
  input  logic ireq_fast,
  input  logic ibus_busy,
  output logic osel_clk,
  output logic ohold,
  output logic oclk_ready,
  output logic oswitch_done,
  output logic otimeout
);

  sd_clk_state_e state, state_next;
  logic sel_next;
  logic sw_flag, sw_flag_next;   // set by SWITCH; gates the done pulse
  logic done_next;
  logic in_drain, in_settle;
  logic idle_hit, settle_hit;

  assign in_drain  = (state == ST_DRAIN);
  assign in_settle = (state == ST_SETTLE);

  // Busy cycles restart the idle run; counter is held at zero outside DRAIN.
  sd_cycle_counter #(.TARGET(IDLE_CYCLES)) u_idle_cnt (
    .clk (iclk),
    .rst (irst),
    .clr (!in_drain || ibus_busy),
    .en  (in_drain && !ibus_busy),
    .hit (idle_hit)
  );

  sd_cycle_counter #(.TARGET(SETTLE_CYCLES)) u_settle_cnt (
    .clk (iclk),
    .rst (irst),
    .clr (!in_settle),
    .en  (in_settle),
    .hit (settle_hit)
  );

`ifdef CLK_SWITCH_TIMEOUT_EN
  logic tmo_hit, tmo, tmo_next;

  sd_cycle_counter #(.TARGET(TIMEOUT_CYCLES)) u_tmo_cnt (
    .clk (iclk),
    .rst (irst),
    .clr (!in_drain),
    .en  (in_drain),
    .hit (tmo_hit)
  );

  assign otimeout = tmo;
`else
  assign otimeout = 1'b0;
`endif

  always_comb begin
    state_next   = state;
    sel_next     = osel_clk;
    sw_flag_next = sw_flag;
`ifdef CLK_SWITCH_TIMEOUT_EN
    tmo_next     = tmo;
`endif
    case (state)
      ST_LOCK_WAIT: begin
        if (ipll_lock) begin
          state_next   = ST_SETTLE;
          sw_flag_next = 1'b0;
        end
      end
      ST_STABLE: begin
        if (ireq_fast != osel_clk) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Abort beats switch; switch beats timeout.
        if (ireq_fast == osel_clk) begin
          state_next = ST_STABLE;
        end else if (idle_hit) begin
          state_next = ST_SWITCH;
`ifdef CLK_SWITCH_TIMEOUT_EN
        end else if (tmo_hit) begin
          state_next = ST_STABLE;
          tmo_next   = 1'b1;
`endif
        end
      end
      ST_SWITCH: begin
        sel_next     = ireq_fast;
        sw_flag_next = 1'b1;
        state_next   = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_hit) state_next = ST_STABLE;
      end
      default: state_next = ST_LOCK_WAIT;
    endcase

    if (!ipll_lock && (state != ST_LOCK_WAIT)) begin
      state_next   = ST_LOCK_WAIT;
      sel_next     = MODE_SLOW;
      sw_flag_next = 1'b0;
`ifdef CLK_SWITCH_TIMEOUT_EN
      tmo_next     = 1'b0;
`endif
    end

    done_next = in_settle && (state_next == ST_STABLE) && sw_flag;
`ifdef CLK_SWITCH_TIMEOUT_EN
    if (done_next) tmo_next = 1'b0;
`endif
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge iclk) begin
    if (irst) begin
      state        <= ST_LOCK_WAIT;
      osel_clk     <= MODE_SLOW;
      ohold        <= 1'b1;
      oclk_ready   <= 1'b0;
      oswitch_done <= 1'b0;
      sw_flag      <= 1'b0;
`ifdef CLK_SWITCH_TIMEOUT_EN
      tmo          <= 1'b0;
`endif
    end else begin
      state        <= state_next;
      osel_clk     <= sel_next;
      ohold        <= (state_next != ST_STABLE);
      oclk_ready   <= (state_next == ST_STABLE) || (state_next == ST_DRAIN);
      oswitch_done <= done_next;
      sw_flag      <= sw_flag_next;
`ifdef CLK_SWITCH_TIMEOUT_EN
      tmo          <= tmo_next;
`endif
    end
  end

endmodule

// File: tb/tb_sd_clk_switch_ctrl.sv
module tb_sd_clk_switch_ctrl;

  localparam int IDLE   = 8;
  localparam int SETTLE = 64;
  localparam int TMO    = 100;

  logic iclk = 1'b0;
  logic irst, ipll_lock, ireq_fast, ibus_busy;
  logic osel_clk, ohold, oclk_ready, oswitch_done, otimeout;

  int checks = 0;
  int errors = 0;
  logic cur_sel;          // mode the bench believes is selected
  logic exp_tmo;          // expected sticky timeout flag
  bit   busy_pat [0:127]; // ibus_busy per drain-relative cycle

  sd_clk_switch_ctrl #(
    .IDLE_CYCLES   (IDLE),
    .SETTLE_CYCLES (SETTLE)
`ifdef CLK_SWITCH_TIMEOUT_EN
    , .TIMEOUT_CYCLES (TMO)
`endif
  ) dut (
    .iclk         (iclk),
    .irst         (irst),
    .ipll_lock    (ipll_lock),
    .ireq_fast    (ireq_fast),
    .ibus_busy    (ibus_busy),
    .osel_clk     (osel_clk),
    .ohold        (ohold),
    .oclk_ready   (oclk_ready),
    .oswitch_done (oswitch_done),
    .otimeout     (otimeout)
  );

  always #5 iclk = ~iclk;

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_sel, input logic e_hold,
                         input logic e_rdy, input logic e_done, input logic e_tmo);
    chk({tag, ".sel"},   osel_clk,     e_sel);
    chk({tag, ".hold"},  ohold,        e_hold);
    chk({tag, ".ready"}, oclk_ready,   e_rdy);
    chk({tag, ".done"},  oswitch_done, e_done);
    chk({tag, ".tmo"},   otimeout,     e_tmo);
  endtask

  function automatic void clear_pat();
    for (int i = 0; i < 128; i++) busy_pat[i] = 1'b0;
  endfunction

  // From STABLE (cycle 0): request the other mode; busy_pat drives the bus.
  // The switch cycle is where the idle run first reaches IDLE, plus one.
  task automatic do_switch(input string tag);
    logic old_sel = cur_sel;
    int run = 0;
    int sw = 0;
    for (int k = 1; k < 128 && sw == 0; k++) begin
      run = busy_pat[k] ? 0 : run + 1;
      if (run == IDLE) sw = k + 1;
    end
    ireq_fast = ~old_sel;
    ibus_busy = busy_pat[0];
    for (int k = 1; k <= sw + SETTLE + 1; k++) begin
      tick();
      ibus_busy = (k < 128) ? busy_pat[k] : 1'b0;
      chk_all(tag,
              (k <= sw) ? old_sel : ~old_sel,
              (k <= sw + SETTLE),
              (k < sw) || (k >= sw + SETTLE + 1),
              (k == sw + SETTLE + 1),
              (k < sw + SETTLE + 1) ? exp_tmo : 1'b0);
    end
    exp_tmo = 1'b0;
    cur_sel = ~old_sel;
    ibus_busy = 1'b0;
  endtask

  // Request then withdraw after n drain cycles (n < IDLE, bus idle).
  task automatic do_abort(input string tag, input int n);
    logic old_sel = cur_sel;
    ireq_fast = ~old_sel;
    ibus_busy = 1'b0;
    for (int k = 1; k <= n + 70; k++) begin
      tick();
      chk_all(tag, old_sel, (k <= n), 1'b1, 1'b0, exp_tmo);
      if (k == n) ireq_fast = old_sel;
    end
  endtask

  // Switch with idle bus; lock lost during SETTLE, regained after a few cycles.
  task automatic do_lock_drop(input string tag);
    logic old_sel = cur_sel;
    int sw = IDLE + 1;
    int p  = sw + 1 + int'($urandom_range(0, SETTLE - 1));
    int q  = p + int'($urandom_range(1, 5));
    ireq_fast = ~old_sel;
    ibus_busy = 1'b0;
    for (int k = 1; k <= p; k++) begin
      tick();
      chk_all({tag, "_pre"}, (k <= sw) ? old_sel : ~old_sel, 1'b1, (k < sw), 1'b0, 1'b0);
    end
    ipll_lock = 1'b0;
    ireq_fast = 1'b0;
    for (int k = p + 1; k <= q + SETTLE + 2; k++) begin
      tick();
      chk_all({tag, "_post"}, 1'b0, (k < q + SETTLE + 1), (k >= q + SETTLE + 1), 1'b0, 1'b0);
      if (k == q) ipll_lock = 1'b1;
    end
    cur_sel = 1'b0;
  endtask

  // Synchronous reset pulse after d drain cycles; lock stays high.
  task automatic do_mid_reset(input string tag, input int d);
    int r;
    ireq_fast = ~cur_sel;
    ibus_busy = 1'b0;
    for (int k = 1; k <= d; k++) tick();
    irst = 1'b1;
    ireq_fast = 1'b0;
    tick();
    r = d + 1;
    chk_all({tag, "_rst"}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    irst = 1'b0;
    for (int k = r + 1; k <= r + SETTLE + 2; k++) begin
      tick();
      chk_all(tag, 1'b0, (k < r + SETTLE + 1), (k >= r + SETTLE + 1), 1'b0, 1'b0);
    end
    cur_sel = 1'b0;
    exp_tmo = 1'b0;
  endtask

  initial begin
    irst = 1'b1;
    ipll_lock = 1'b0;
    ireq_fast = 1'b0;
    ibus_busy = 1'b0;
    cur_sel = 1'b0;
    exp_tmo = 1'b0;
    repeat (3) tick();
    chk_all("reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    irst = 1'b0;

    // Lock at cycle 5: ready at 5 + SETTLE + 1, never a done pulse.
    for (int k = 1; k <= 72; k++) begin
      tick();
      chk_all("lock_up", 1'b0, (k < 70), (k >= 70), 1'b0, 1'b0);
      if (k == 5) ipll_lock = 1'b1;
    end

    clear_pat();
    do_switch("to_fast_idle");

    clear_pat();
    busy_pat[5] = 1'b1;
    do_switch("busy_cyc5");

    clear_pat();
    busy_pat[8] = 1'b1;
    do_switch("busy_cyc8");

    for (int i = 0; i < 6; i++) begin
      clear_pat();
      for (int k = 1; k < 40; k++) busy_pat[k] = ($urandom_range(0, 2) == 0);
      do_switch("rand_busy");
    end

    do_abort("abort3", 3);
    for (int i = 0; i < 3; i++) do_abort("abort_rand", int'($urandom_range(1, IDLE - 1)));

    do_lock_drop("lock_drop_a");
    do_lock_drop("lock_drop_b");

    do_mid_reset("mid_reset", int'($urandom_range(1, IDLE - 1)));

`ifdef CLK_SWITCH_TIMEOUT_EN
    begin : timeout_case
      logic old_sel = cur_sel;
      ireq_fast = ~old_sel;
      ibus_busy = 1'b1;
      for (int k = 1; k <= TMO + 1; k++) begin
        tick();
        chk_all("timeout", old_sel, (k <= TMO), 1'b1, 1'b0, (k >= TMO + 1));
      end
      exp_tmo = 1'b1;
      clear_pat();
      do_switch("after_timeout");
      // Idle threshold met on the same edge as the timeout: switch wins.
      clear_pat();
      for (int k = 1; k <= TMO - IDLE; k++) busy_pat[k] = 1'b1;
      do_switch("tmo_vs_idle");
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
